// File: rtl/dco_meter_pkg.sv
// Shared types and defaults for the DCO frequency meter and its consumers.
package dco_meter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      GATE   = 2'd2
   } state_t;

   localparam int unsigned DEF_GATE_CYCLES = 100;
   localparam int unsigned DEF_CNT_W       = 16;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   // Width of a counter that runs 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dco_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module dco_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the async input through the synchroniser and keep the last stage's previous value.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/dco_freq_meter.sv
// Counts synchronised DCO rising edges over a fixed gate window of clk
// cycles; single-shot or back-to-back continuous windows, saturating result.
module dco_freq_meter
   import dco_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dco_in,
   input  logic             start,
   input  logic             cont,
   output logic [CNT_W-1:0] count,
   output logic             count_valid,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned GW = cnt_width(GATE_CYCLES);
   localparam int unsigned SW = cnt_width(SYNC_STAGES);
   localparam logic [CNT_W-1:0] ACC_MAX = '1;
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SYNC_STAGES - 1);

   logic rise;

   dco_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (dco_in),
      .rise     (rise)
   );

   state_t             state_q, state_d;
   logic [SW-1:0]      settle_q, settle_d;
   logic [GW-1:0]      gate_q, gate_d;
   logic [CNT_W-1:0]   acc_q, acc_d;
   logic               sat_q, sat_d;
   logic [CNT_W-1:0]   acc_next;
   logic               sat_next;
   logic               load;

   // Window FSM: next state, counters and end-of-gate result strobe.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      gate_d   = gate_q;
      acc_d    = acc_q;
      sat_d    = sat_q;
      acc_next = acc_q;
      sat_next = sat_q;
      load     = 1'b0;

      // Saturating accumulate; an edge arriving at full scale is dropped and flagged.
      if (rise) begin
         if (acc_q == ACC_MAX) sat_next = 1'b1;
         else                  acc_next = acc_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (start | cont) begin
               state_d  = SETTLE;
               settle_d = '0;
            end
         end
         SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = GATE;
               gate_d  = '0;
               acc_d   = '0;
               sat_d   = 1'b0;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         GATE: begin
            acc_d = acc_next;
            sat_d = sat_next;
            if (gate_q == GATE_LAST) begin
               // Result latches from acc_next while the window restarts in the same cycle.
               load    = 1'b1;
               gate_d  = '0;
               acc_d   = '0;
               sat_d   = 1'b0;
               state_d = cont ? GATE : IDLE;
            end else begin
               gate_d = gate_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         settle_q <= '0;
         gate_q   <= '0;
         acc_q    <= '0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         gate_q   <= gate_d;
         acc_q    <= acc_d;
         sat_q    <= sat_d;
      end
   end

   // Result registers: count/ovf held between windows, valid pulses once per window.
   always_ff @(posedge clk) begin
      if (reset) begin
         count       <= '0;
         ovf         <= 1'b0;
         count_valid <= 1'b0;
      end else begin
         count_valid <= load;
         if (load) begin
            count <= acc_next;
            ovf   <= sat_next;
         end
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dco_freq_meter.sv
// Self-checking bench for dco_freq_meter: randomly phased DCO stimulus,
// expected counts derived from logged DCO rising edges per clk edge.
module tb_dco_freq_meter;
   import dco_meter_pkg::*;

   localparam int unsigned G  = DEF_GATE_CYCLES;
   localparam int unsigned S  = DEF_SYNC_STAGES;
   localparam int unsigned W  = DEF_CNT_W;
   localparam int unsigned W4 = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          dco_in;
   logic          start;
   logic          cont;
   logic [W-1:0]  count;
   logic          count_valid, ovf, busy;
   logic [W4-1:0] count4;
   logic          count_valid4, ovf4, busy4;

   int vectors     = 0;
   int miscompares = 0;

   int unsigned cyc = 0;
   int unsigned rises[$];
   logic        last_s = 1'b0;

   int unsigned half      = 40;
   bit          dco_run   = 1'b0;
   logic        dco_level = 1'b0;

   dco_freq_meter #(.GATE_CYCLES(G), .CNT_W(W), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .dco_in(dco_in), .start(start), .cont(cont),
      .count(count), .count_valid(count_valid), .ovf(ovf), .busy(busy)
   );

   dco_freq_meter #(.GATE_CYCLES(G), .CNT_W(W4), .SYNC_STAGES(S)) dut4 (
      .clk(clk), .reset(reset), .dco_in(dco_in), .start(start), .cont(cont),
      .count(count4), .count_valid(count_valid4), .ovf(ovf4), .busy(busy4)
   );

   always #10 clk = ~clk;

   // Edge index of every clk edge that first sees dco_in high after low.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (dco_in === 1'b1 && last_s === 1'b0) rises.push_back(cyc);
      last_s = dco_in;
   end

   // DCO source: static level, or a square wave whose edges never meet a clk edge.
   initial begin
      dco_in = 1'b0;
      forever begin
         if (dco_run) begin
            int unsigned ph;
            ph = $urandom_range(60, 1);
            if ((($time + ph) % 10) == 0) ph = ph + 1;
            #(ph);
            while (dco_run) begin
               dco_in = ~dco_in;
               #(half);
            end
         end else begin
            dco_in = dco_level;
            #1;
         end
      end
   end

   function automatic int unsigned rises_in(input int unsigned lo, input int unsigned hi);
      int unsigned n = 0;
      foreach (rises[i]) if (rises[i] >= lo && rises[i] <= hi) n++;
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int unsigned budget, input bit use4, output bit got);
      got = 1'b0;
      for (int unsigned i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if ((use4 ? count_valid4 : count_valid) === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic kick(output int unsigned k);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; k = cyc; start = 1'b0;
   endtask

   task automatic dco_wave(input int unsigned h);
      dco_run = 1'b0;
      repeat (8) @(posedge clk);
      half    = h;
      dco_run = 1'b1;
      repeat ($urandom_range(20, 5)) @(posedge clk);
   endtask

   task automatic dco_static(input logic lvl);
      dco_level = lvl;
      dco_run   = 1'b0;
      repeat (8) @(posedge clk);
   endtask

   // Single window: valid timing, modelled count/ovf, then idle again.
   task automatic run_single(input string tag, input bit use4, output int unsigned n);
      int unsigned k, mx;
      bit got;
      mx = use4 ? 15 : 65535;
      kick(k);
      wait_valid(S + G + 20, use4, got);
      check({tag, "_valid"}, got, 1);
      check({tag, "_latency"}, cyc - k, S + G);
      n = rises_in(k + 1, k + G);
      if (use4) begin
         check({tag, "_count"}, count4, (n > mx) ? mx : n);
         check({tag, "_ovf"}, ovf4, (n > mx) ? 1 : 0);
      end else begin
         check({tag, "_count"}, count, (n > mx) ? mx : n);
         check({tag, "_ovf"}, ovf, (n > mx) ? 1 : 0);
      end
      @(posedge clk); #1;
      check({tag, "_pulse_end"}, use4 ? count_valid4 : count_valid, 0);
      check({tag, "_busy_end"}, use4 ? busy4 : busy, 0);
   endtask

   initial begin
      int unsigned n, k, nv;
      bit got;

      reset = 1'b1; start = 1'b0; cont = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_count", count, 0);
      check("rst_valid", count_valid, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
      check("rst_busy4", busy4, 0);
      @(negedge clk); reset = 1'b0;

      // 80 ns DCO: exactly 25 edges per 100-cycle window.
      dco_wave(40);
      run_single("t1", 1'b0, n);
      check("t1_count25", count, 25);

      // 60 ns DCO with random phase: 33 or 34 edges.
      for (int r = 0; r < 20; r++) begin
         dco_wave(30);
         run_single($sformatf("t2_%0d", r), 1'b0, n);
         check($sformatf("t2_set_%0d", r), (count == 33 || count == 34) ? 1 : 0, 1);
      end

      // Random DCO periods, all slower than clk/2.
      for (int r = 0; r < 8; r++) begin
         dco_wave(10 * $urandom_range(10, 3));
         run_single($sformatf("trnd_%0d", r), 1'b0, n);
      end

      // Static DCO levels.
      dco_static(1'b0);
      run_single("t3_low", 1'b0, n);
      check("t3_low_zero", count, 0);
      dco_static(1'b1);
      run_single("t3_high", 1'b0, n);
      check("t3_high_zero", count, 0);

      // Step whose synchronised rise lands in SETTLE is not counted.
      dco_static(1'b0);
      @(negedge clk); start = 1'b1; dco_level = 1'b1;
      @(posedge clk); #1; k = cyc; start = 1'b0;
      wait_valid(S + G + 20, 1'b0, got);
      check("t3_step_valid", got, 1);
      check("t3_step_model", count, rises_in(k + 1, k + G));
      check("t3_step_zero", count, 0);
      dco_static(1'b0);

      // 4-bit result saturates, then clears on a quiet window.
      dco_wave(40);
      run_single("t4_sat", 1'b1, n);
      check("t4_sat15", count4, 15);
      check("t4_ovf1", ovf4, 1);
      dco_static(1'b0);
      run_single("t4_quiet", 1'b1, n);
      check("t4_quiet_ovf0", ovf4, 0);

      // Continuous windows, cont dropped mid-window 5.
      dco_wave(40);
      @(negedge clk); cont = 1'b1;
      @(posedge clk); #1; k = cyc;
      for (int unsigned w = 0; w < 5; w++) begin
         if (w == 4) begin
            repeat (50) @(negedge clk);
            cont = 1'b0;
         end
         wait_valid(G + 20, 1'b0, got);
         check($sformatf("t5_valid_%0d", w), got, 1);
         check($sformatf("t5_time_%0d", w), cyc - k, S + G * (w + 1));
         check($sformatf("t5_model_%0d", w), count, rises_in(k + 1 + G * w, k + G * (w + 1)));
         check($sformatf("t5_count_%0d", w), count, 25);
      end
      @(posedge clk); #1;
      check("t5_busy_end", busy, 0);
      wait_valid(150, 1'b0, got);
      check("t5_no_more", got, 0);

      // start while busy is ignored.
      kick(k);
      nv = 0;
      for (int unsigned i = 0; i < S + G + 60; i++) begin
         if (i == 20) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
         end
         @(posedge clk); #1;
         if (count_valid === 1'b1) nv++;
      end
      check("t6_one_valid", nv, 1);
      check("t6_count", count, 25);

      // Reset at gate cycle 50 aborts the window.
      kick(k);
      repeat (S + 50) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_count", count, 0);
      check("t6_rst_valid", count_valid, 0);
      @(negedge clk); reset = 1'b0;
      wait_valid(150, 1'b0, got);
      check("t6_rst_no_valid", got, 0);

      dco_run = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dco_freq_meter.md
Name: dco_freq_meter

Overview:
Downstream measurement stage for the DCO output. It synchronises the asynchronous dco_out into the system clock domain and counts its rising edges over a fixed gate window of GATE_CYCLES clk cycles. It reports a saturating edge count with a one-cycle valid pulse, in single-shot or continuous mode. Its results are used to characterise DCO frequency against dco_code, and later to close a frequency loop.

Parameters:
GATE_CYCLES, 100, gate window length in clk cycles (>=2)
CNT_W, 16, width of the edge count result
SYNC_STAGES, 2, flip-flop depth of the dco_in synchroniser (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dco_in  in  1  DCO output; asynchronous to clk
start  in  1  single-shot request; sampled only in IDLE
cont  in  1  continuous mode; back-to-back windows while high
count  out  CNT_W  last completed window's edge count; held between windows
count_valid  out  1  one-cycle pulse when count updates
ovf  out  1  last window saturated; updates together with count
busy  out  1  high in SETTLE or GATE

Behaviour:
- Reset (synchronous, active-high): state=IDLE; count=0, count_valid=0, ovf=0, busy=0; synchroniser flops, edge-detect flop, gate counter and edge accumulator all cleared. Reset mid-window aborts it, and no valid is issued.
- Synchroniser: SYNC_STAGES flops, then an edge-detect flop. rise = sync_last & ~prev. The meter is accurate only when dco_in high and low phases are each >=1 clk period (f_dco < f_clk/2). Faster inputs alias; this is documented, not flagged.
- State machine:
  - IDLE: on (start | cont), go to SETTLE. busy goes high the next cycle.
  - SETTLE: lasts exactly SYNC_STAGES cycles. rise is ignored so stale synchroniser contents do not count. Then GATE.
  - GATE: lasts exactly GATE_CYCLES cycles. Gate counter runs 0..GATE_CYCLES-1, and each cycle with rise=1 increments the accumulator.
- End of gate: on the final GATE cycle, acc + rise is loaded into count (saturating). ovf is set if saturation occurred.
- Accumulator saturates at 2^CNT_W-1; further edges are dropped.
- count_valid is registered: high for exactly the one cycle after the final GATE cycle.
- Latency (single shot): start sampled at edge k. SETTLE occupies cycles k+1..k+S and GATE occupies k+S+1..k+S+G. count/count_valid are visible in cycle k+S+G+1 (S=SYNC_STAGES, G=GATE_CYCLES).
- Continuous mode:
  - If cont=1 during the final GATE cycle, the state stays GATE. The gate counter and accumulator reload to 0 in the same cycle the result is latched.
  - There is no dead time and no resettle, so count_valid pulses every GATE_CYCLES cycles exactly.
  - If cont=0 at that point, the state goes to IDLE.
- Simultaneous/boundary cases:
  - start while busy: ignored, no queueing.
  - cont falling mid-window: the current window completes normally.
  - start and cont both high in IDLE: the same as cont.
  - A rise on the final GATE cycle is counted in the closing window.
  - A rise during a SETTLE or IDLE cycle is never counted.
- Width rules: gate counter width is $clog2(GATE_CYCLES). The accumulator is CNT_W bits with a 1-bit saturating increment. No truncation wrap ever occurs.

Decomposition:
- Package dco_meter_pkg:
  - state enum {IDLE, SETTLE, GATE}
  - localparam helper for gate counter width
  - default CNT_W/GATE_CYCLES constants shared with the DCO top and testbench
- Sub-module dco_sync_edge: SYNC_STAGES synchroniser plus rising-edge detector. Parameter SYNC_STAGES; ports clk, reset, async_in, rise. Reused later by other consumers of dco_out.

Test Plan:
1. clk 20 ns, dco_in period 80 ns (40/40), G=100, S=2, start pulse -> single count_valid 103 cycles after start sample, count=25, ovf=0, busy low afterwards.
2. dco_in period 60 ns (30/30), G=100 -> count in {33,34}. Repeat 20 runs with random phase; every result is in that set.
3. dco_in held at 0, then held at 1 (static), start -> count=0, ovf=0. A dco_in step 0->1 during SETTLE is not counted -> count=0.
4. CNT_W=4, dco_in period 80 ns, G=100 -> count=15, ovf=1. The next window with dco_in static gives count=0, ovf=0.
5. cont held high for 5 windows, dco_in period 80 ns -> count_valid pulses exactly 100 cycles apart, each count=25. Drop cont mid-window 5 -> that window still reports 25, then IDLE, busy=0.
6. Assert reset for 1 cycle at GATE cycle 50 -> next cycle state=IDLE, busy=0, count=0, no count_valid. start during GATE is ignored: only one valid results.
